// File: rtl/rs232_rx.sv
// rs232_rx: 8N1 UART receiver with 16x oversampling, 3-sample majority vote
// and a first-word-fall-through receive FIFO on a valid/ready port.
//
// Handshake: a byte leaves the FIFO on every clk edge where rx_valid && rx_ready
// are both high. rx_data/rx_valid describe the head entry and may change only
// after such a pop or after a push into an empty FIFO. rx_ready has no effect
// while rx_valid is low.
module rs232_rx #(
    parameter int CLK_HZ     = 48_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // Rounded divider: one tick per 1/16 bit time.
    localparam int DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state;
    logic          rs_meta;
    logic          rs;
    logic          rs_prev;
    logic [CW-1:0] div_cnt;
    logic [3:0]    sc;
    logic          s0;
    logic          s1;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic          tick;
    logic          vote_ev;
    logic          vote;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rs_meta <= 1'b1;
            rs      <= 1'b1;
            rs_prev <= 1'b1;
        end else begin
            rs_meta <= rx;
            rs      <= rs_meta;
            rs_prev <= rs;
        end
    end

    // sc counts ticks within a bit; samples are taken on the ticks that move sc
    // to 7, 8 and 9, the third one being the live rs used directly in the vote.
    assign tick    = (state != S_IDLE) && (div_cnt == DIV_LAST);
    assign vote_ev = tick && (sc == 4'd8);
    assign vote    = (s0 & s1) | (s0 & rs) | (s1 & rs);
    assign busy    = (state != S_IDLE);

    // Receive FSM with its tick divider, sample counter and shift register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            sc        <= '0;
            s0        <= 1'b0;
            s1        <= 1'b0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            if (state == S_IDLE || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end

            if (tick) begin
                sc <= sc + 4'd1;
                if (sc == 4'd6) s0 <= rs;
                if (sc == 4'd7) s1 <= rs;
            end

            case (state)
                S_IDLE: begin
                    if (rs_prev && !rs) begin
                        state <= S_START;
                        sc    <= '0;
                        s0    <= 1'b0;
                        s1    <= 1'b0;
                    end
                end
                S_START: begin
                    if (vote_ev) begin
                        if (vote) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (vote_ev) begin
                        shreg <= {vote, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    // Leave mid-stop-bit so a back-to-back start edge is not missed.
                    if (vote_ev) begin
                        if (vote) begin
                            state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rs) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign push     = (state == S_STOP) && vote_ev && vote;
    assign pop      = rx_valid && rx_ready;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rx_valid = !empty;
    assign rx_data  = mem[rd_ptr[AW-1:0]];

    // Receive FIFO; a push into a full FIFO survives only if a pop frees a slot.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            overrun <= push && full && !pop;
            if (push && (!full || pop)) begin
                mem[wr_ptr[AW-1:0]] <= shreg;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule
